// File: rtl/sr_arb_pkg.sv
// Shared definitions for the SR flag arbiter: command op codes, FSM states and
// the rule for which value a flag should hold once a command has been applied.
package sr_arb_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_CLR = 2'b01,
        OP_SET = 2'b10,
        OP_TGL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CHECK = 2'd2
    } state_e;

    function automatic logic expected_q(op_e op, logic cur);
        logic res;
        case (op)
            OP_SET:  res = 1'b1;
            OP_CLR:  res = 1'b0;
            OP_TGL:  res = ~cur;
            default: res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester found when scanning from
// ptr upwards (wrapping) wins, reported both one-hot and as an index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!any && req[i] && (i == (int'(ptr) + k) % NREQ)) begin
                    any      = 1'b1;
                    grant[i] = 1'b1;
                    grant_id = IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin front end for a shared bank of SR flops: accepts one command per
// three cycles, fires a single S or R pulse, then reads the flag back.
module sr_flag_arbiter
    import sr_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [2*NREQ-1:0]       req_op,
    input  logic [IDXW*NREQ-1:0]    req_idx,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NFLAG-1:0]        flag_q,
    output logic [NFLAG-1:0]        sr_s,
    output logic [NFLAG-1:0]        sr_r,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic                    done_err
);

    localparam int IDW = $clog2(NREQ);

    state_e            state;
    logic [IDW-1:0]    rr_ptr;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    win_id;
    logic [IDW-1:0]    next_ptr;
    logic              win_any;
    op_e               sel_op;
    logic [IDXW-1:0]   sel_idx;

    logic [IDW-1:0]    cmd_id;
    op_e               cmd_op;
    logic [IDXW-1:0]   cmd_idx;
    logic              cmd_exp;
    logic [NFLAG-1:0]  pulse_s;
    logic [NFLAG-1:0]  pulse_r;

    logic              chk_pend;
    logic [IDW-1:0]    chk_id;
    op_e               chk_op;
    logic [IDXW-1:0]   chk_idx;
    logic              chk_exp;

    function automatic logic in_range(logic [IDXW-1:0] i);
        return int'(i) < NFLAG;
    endfunction

    function automatic logic flag_at(logic [NFLAG-1:0] q, logic [IDXW-1:0] i);
        logic res;
        res = 1'b0;
        for (int f = 0; f < NFLAG; f++) begin
            if (i == IDXW'(f)) res = q[f];
        end
        return res;
    endfunction

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .grant_id (win_id),
        .any      (win_any)
    );

    assign req_ready = (state == S_IDLE && rst) ? grant : '0;
    assign busy      = (state == S_ISSUE) || (state == S_CHECK);
    assign next_ptr  = (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;

    always_comb begin
        sel_op  = OP_NOP;
        sel_idx = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (win_id == IDW'(r)) begin
                sel_op  = op_e'(req_op[2*r +: 2]);
                sel_idx = req_idx[IDXW*r +: IDXW];
            end
        end
    end

    // An out-of-range index matches no flag, so it naturally produces no pulse.
    always_comb begin
        pulse_s = '0;
        pulse_r = '0;
        for (int f = 0; f < NFLAG; f++) begin
            if (cmd_op != OP_NOP && cmd_idx == IDXW'(f)) begin
                pulse_s[f] = cmd_exp;
                pulse_r[f] = ~cmd_exp;
            end
        end
    end

    // chk_* holds the finished command for one extra cycle so the readback
    // sees flag_q after the bank has captured the pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            cmd_id   <= '0;
            cmd_op   <= OP_NOP;
            cmd_idx  <= '0;
            cmd_exp  <= 1'b0;
            chk_pend <= 1'b0;
            chk_id   <= '0;
            chk_op   <= OP_NOP;
            chk_idx  <= '0;
            chk_exp  <= 1'b0;
            sr_s     <= '0;
            sr_r     <= '0;
            done     <= 1'b0;
            done_id  <= '0;
            done_err <= 1'b0;
        end else begin
            sr_s     <= '0;
            sr_r     <= '0;
            done     <= 1'b0;
            done_err <= 1'b0;
            chk_pend <= 1'b0;
            if (chk_pend) begin
                done     <= 1'b1;
                done_id  <= chk_id;
                done_err <= !in_range(chk_idx) ||
                            (chk_op != OP_NOP && flag_at(flag_q, chk_idx) != chk_exp);
            end
            case (state)
                S_IDLE: begin
                    if (win_any) begin
                        cmd_id  <= win_id;
                        cmd_op  <= sel_op;
                        cmd_idx <= sel_idx;
                        cmd_exp <= expected_q(sel_op, flag_at(flag_q, sel_idx));
                        rr_ptr  <= next_ptr;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    sr_s  <= pulse_s;
                    sr_r  <= pulse_r;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    chk_pend <= 1'b1;
                    chk_id   <= cmd_id;
                    chk_op   <= cmd_op;
                    chk_idx  <= cmd_idx;
                    chk_exp  <= cmd_exp;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed and random bench for sr_flag_arbiter driving a behavioural SR flop
// bank; a second instance with NFLAG=6 covers out-of-range indices.
module tb_sr_flag_arbiter;

    localparam int NREQ  = 4;
    localparam int NFLAG = 8;
    localparam int IDXW  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [7:0]  req_op = '0;
    logic [11:0] req_idx = '0;
    logic [3:0]  req_ready;
    logic [7:0]  sr_s, sr_r;
    logic        busy, done, done_err;
    logic [1:0]  done_id;

    logic [7:0]  bank = '0;
    logic        load_en = 1'b0;
    logic [7:0]  load_val = '0;
    logic        force3 = 1'b0;

    logic [3:0]  v6_valid = '0;
    logic [7:0]  v6_op = '0;
    logic [11:0] v6_idx = '0;
    logic [3:0]  v6_ready;
    logic [5:0]  bank6 = '0;
    logic [5:0]  s6, r6;
    logic        busy6, done6, err6;
    logic [1:0]  id6;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_count = 0;
    logic clean = 1'b0;
    int sb_id[$];
    int sb_cyc[$];

    typedef struct {
        logic [3:0] valid;
        int         id;
        logic [1:0] op;
        logic [2:0] idx;
        logic [7:0] init;
        logic [7:0] exp_s;
        logic [7:0] exp_r;
        logic [7:0] exp_q;
        logic       exp_err;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_idx(req_idx), .req_ready(req_ready), .flag_q(bank),
        .sr_s(sr_s), .sr_r(sr_r), .busy(busy), .done(done),
        .done_id(done_id), .done_err(done_err)
    );

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(6), .IDXW(IDXW)) dut6 (
        .clk(clk), .rst(rst), .req_valid(v6_valid), .req_op(v6_op),
        .req_idx(v6_idx), .req_ready(v6_ready), .flag_q(bank6),
        .sr_s(s6), .sr_r(r6), .busy(busy6), .done(done6),
        .done_id(id6), .done_err(err6)
    );

    // SR flop banks (their own reset is tied inactive); force3 models another agent clearing flag 3.
    always @(posedge clk) begin
        if (load_en) begin
            bank <= load_val;
        end else begin
            for (int f = 0; f < 8; f++) begin
                if (sr_s[f]) bank[f] <= 1'b1;
                else if (sr_r[f]) bank[f] <= 1'b0;
            end
            if (force3) bank[3] <= 1'b0;
        end
        for (int f = 0; f < 6; f++) begin
            if (s6[f]) bank6[f] <= 1'b1;
            else if (r6[f]) bank6[f] <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh2idx(logic [3:0] v);
        int res;
        res = -1;
        for (int i = 0; i < 4; i++) if (v[i]) res = i;
        return res;
    endfunction

    // Monitor: pulse invariants, and a scoreboard pairing every accept with one done 4 negedges later.
    always @(negedge clk) begin
        if (!rst) begin
            sb_id.delete();
            sb_cyc.delete();
        end else begin
            cyc++;
            checkOutput("s_and_r", 32'(sr_s & sr_r), 0);
            checkOutput("onehot_pulse", 32'($onehot0(sr_s | sr_r)), 1);
            checkOutput("onehot_ready", 32'($onehot0(req_ready)), 1);
            checkOutput("s6_and_r6", 32'(s6 & r6), 0);
            if (done) begin
                done_count++;
                checkOutput("done_has_accept", 32'(sb_id.size() != 0), 1);
                if (sb_id.size() != 0) begin
                    checkOutput("sb_done_id", 32'(done_id), sb_id.pop_front());
                    checkOutput("sb_latency", cyc - sb_cyc.pop_front(), 4);
                end
                if (clean) checkOutput("rand_done_err", 32'(done_err), 0);
            end
            if ((req_valid & req_ready) != 0) begin
                sb_id.push_back(oh2idx(req_valid & req_ready));
                sb_cyc.push_back(cyc);
            end
        end
    end

    task automatic applyStimulus(input int n, input vec_t v);
        @(posedge clk); #1;
        load_en  = 1'b1;
        load_val = v.init;
        @(posedge clk); #1;
        load_en   = 1'b0;
        req_valid = v.valid;
        for (int r = 0; r < 4; r++) begin
            req_op[2*r +: 2]  = (r == v.id) ? v.op : 2'b11;
            req_idx[3*r +: 3] = (r == v.id) ? v.idx : v.idx + 3'd1;
        end
        #1 checkOutput($sformatf("v%0d_ready", n), 32'(req_ready), 32'(1 << v.id));
        @(posedge clk); #1;
        req_valid = '0;
        checkOutput($sformatf("v%0d_busy", n), 32'(busy), 1);
        @(posedge clk); #1;
        checkOutput($sformatf("v%0d_sr_s", n), 32'(sr_s), 32'(v.exp_s));
        checkOutput($sformatf("v%0d_sr_r", n), 32'(sr_r), 32'(v.exp_r));
        @(posedge clk); #1;
        checkOutput($sformatf("v%0d_pulse_end", n), 32'({sr_s, sr_r}), 0);
        checkOutput($sformatf("v%0d_flags", n), 32'(bank), 32'(v.exp_q));
        @(posedge clk); #1;
        checkOutput($sformatf("v%0d_done", n), 32'(done), 1);
        checkOutput($sformatf("v%0d_done_id", n), 32'(done_id), v.id);
        checkOutput($sformatf("v%0d_done_err", n), 32'(done_err), 32'(v.exp_err));
        @(posedge clk); #1;
        checkOutput($sformatf("v%0d_done_low", n), 32'(done), 0);
    endtask

    task automatic run6(input logic [2:0] idx, input logic [5:0] exp_s, input logic exp_err);
        @(posedge clk); #1;
        v6_valid = 4'b0001;
        v6_op    = 8'h02;
        v6_idx   = {9'd0, idx};
        #1 checkOutput("n6_ready", 32'(v6_ready), 1);
        @(posedge clk); #1;
        v6_valid = '0;
        @(posedge clk); #1;
        checkOutput("n6_sr_s", 32'(s6), 32'(exp_s));
        checkOutput("n6_sr_r", 32'(r6), 0);
        @(posedge clk); #1;
        checkOutput("n6_pulse_end", 32'({s6, r6}), 0);
        @(posedge clk); #1;
        checkOutput("n6_done", 32'(done6), 1);
        checkOutput("n6_done_id", 32'(id6), 0);
        checkOutput("n6_done_err", 32'(err6), 32'(exp_err));
    endtask

    initial begin
        int gid[5];
        int gcyc[5];
        int ng;
        int dc;
        int t;

        vecs[0] = '{4'b0001, 0, 2'b10, 3'd5, 8'h00, 8'h20, 8'h00, 8'h20, 1'b0};
        vecs[1] = '{4'b0100, 2, 2'b11, 3'd2, 8'h04, 8'h00, 8'h04, 8'h00, 1'b0};
        vecs[2] = '{4'b1000, 3, 2'b01, 3'd7, 8'h80, 8'h00, 8'h80, 8'h00, 1'b0};
        vecs[3] = '{4'b0010, 1, 2'b00, 3'd1, 8'h02, 8'h00, 8'h00, 8'h02, 1'b0};
        vecs[4] = '{4'b0001, 0, 2'b10, 3'd0, 8'h01, 8'h01, 8'h00, 8'h01, 1'b0};
        vecs[5] = '{4'b1111, 1, 2'b11, 3'd6, 8'h00, 8'h40, 8'h00, 8'h40, 1'b0};
        vecs[6] = '{4'b1001, 3, 2'b01, 3'd4, 8'hFF, 8'h00, 8'h10, 8'hEF, 1'b0};
        vecs[7] = '{4'b0110, 1, 2'b10, 3'd3, 8'h00, 8'h08, 8'h00, 8'h08, 1'b0};
        vecs[8] = '{4'b0100, 2, 2'b01, 3'd1, 8'h00, 8'h00, 8'h02, 8'h00, 1'b0};

        $display("[TB] reset values");
        req_valid = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(req_ready), 0);
        checkOutput("rst_pulses", 32'({sr_s, sr_r}), 0);
        checkOutput("rst_done", 32'({done, done_id, done_err}), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;

        $display("[TB] reset during ISSUE");
        req_valid = 4'b0001;
        req_op    = 8'h02;
        req_idx   = 12'd5;
        @(posedge clk); #1;
        checkOutput("mid_busy", 32'(busy), 1);
        dc  = done_count;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_pulses", 32'({sr_s, sr_r}), 0);
        checkOutput("mid_rst_busy", 32'(busy), 0);
        checkOutput("mid_rst_ready", 32'(req_ready), 0);
        checkOutput("mid_rst_done", 32'(done), 0);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("mid_rst_flag5", 32'(bank), 0);
        checkOutput("mid_rst_no_done", done_count, dc);

        $display("[TB] directed vector table");
        for (int i = 0; i < 9; i++) applyStimulus(i, vecs[i]);

        $display("[TB] round-robin rotation");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 4'hF;
        req_op    = 8'h00;
        req_idx   = '0;
        ng = 0;
        t  = 0;
        while (ng < 5 && t < 40) begin
            @(negedge clk);
            t++;
            if (req_ready != 0) begin
                gid[ng]  = oh2idx(req_ready);
                gcyc[ng] = t;
                ng++;
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        checkOutput("rr_grants", ng, 5);
        for (int k = 0; k < ng; k++) checkOutput($sformatf("rr_grant%0d", k), gid[k], k % 4);
        for (int k = 1; k < ng; k++) checkOutput($sformatf("rr_gap%0d", k), gcyc[k] - gcyc[k-1], 3);
        repeat (6) @(posedge clk);

        $display("[TB] readback conflict");
        #1;
        load_en  = 1'b1;
        load_val = 8'h00;
        @(posedge clk); #1;
        load_en   = 1'b0;
        req_valid = 4'b0010;
        req_op    = 8'h08;
        req_idx   = 12'o0030;
        #1 checkOutput("cf_ready", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = '0;
        force3    = 1'b1;
        @(posedge clk); #1;
        checkOutput("cf_sr_s", 32'(sr_s), 32'h08);
        @(posedge clk); #1;
        checkOutput("cf_flag3", 32'(bank[3]), 0);
        @(posedge clk); #1;
        force3 = 1'b0;
        checkOutput("cf_done", 32'(done), 1);
        checkOutput("cf_done_id", 32'(done_id), 1);
        checkOutput("cf_done_err", 32'(done_err), 1);

        $display("[TB] NFLAG=6 index range");
        run6(3'd7, 6'h00, 1'b1);
        run6(3'd6, 6'h00, 1'b1);
        run6(3'd5, 6'h20, 1'b0);
        @(posedge clk); #1;
        checkOutput("n6_flag5", 32'(bank6), 32'h20);

        $display("[TB] random traffic");
        repeat (3) @(posedge clk);
        clean = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            req_valid = 4'($urandom_range(0, 15));
            req_op    = 8'($urandom);
            req_idx   = 12'($urandom);
        end
        req_valid = '0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("drain_pending", sb_id.size(), 0);
        checkOutput("drain_idle", 32'({busy, done}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
